// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the frame-format enums, state encoding and input decode helpers.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int MIN_BAUD_DIV = 4;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    MARK  = 3'd3,
    SPACE = 3'd4
  } parity_e;

  typedef enum logic [1:0] {
    STOP1   = 2'd0,
    STOP2   = 2'd1,
    STOP1_5 = 2'd2
  } stop_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Codes 5..7 are reserved and behave as no parity.
  function automatic parity_e to_parity(input logic [2:0] code);
    case (code)
      3'd1:    return EVEN;
      3'd2:    return ODD;
      3'd3:    return MARK;
      3'd4:    return SPACE;
      default: return NONE;
    endcase
  endfunction

  function automatic stop_e to_stop(input logic [1:0] code);
    case (code)
      2'd1:    return STOP2;
      2'd2:    return STOP1_5;
      default: return STOP1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Upstream byte stream into the UART transmitter: level-based valid/ready.
// A word transfers on any clk edge where s_valid and s_ready are both high.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, s_valid, input s_ready);
  modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, head word visible combinationally (no read latency).
// Pushes while full and pops while empty are ignored; level uses a wrap bit.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter, 5-8 data bits, parity, 1/1.5/2 stop; first tx fall 1 clk after push.
// Backpressure: s_ready = !full. Optional UART_TX_CTS_EN adds cts_n flow control on frame start.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_buffered_if.slave             s,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [2:0]                    parity,
  input  logic [1:0]                    stop_bits,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_TX_CTS_EN
  ,
  input  logic                          cts_n
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              cts_ok;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level_nxt;

  tx_state_e         state;
  logic [DIV_W:0]    cnt;
  logic [DIV_W:0]    bit_tc;
  logic [DIV_W:0]    stop_tc;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic [2:0]        last_bit;
  logic              par_en;
  logic              par_bit;

  logic [DIV_W:0]    div_eff;
  logic [DIV_W:0]    stop_tc_new;
  logic [DATA_W-1:0] data_mask;
  logic              par_bit_new;
  logic              bit_done;
  logic              stop_done;

  assign push      = s.s_valid && !full;
  assign s.s_ready = !full;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s.s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // Frame config is decoded continuously but only captured on the pop edge.
  always_comb begin
    div_eff = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? (DIV_W+1)'(MIN_BAUD_DIV)
                                                : {1'b0, baud_div};
    case (to_stop(stop_bits))
      STOP2:   stop_tc_new = {div_eff[DIV_W-1:0], 1'b0};
      STOP1_5: stop_tc_new = div_eff + (div_eff >> 1);
      default: stop_tc_new = div_eff;
    endcase
    case (data_bits)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    case (to_parity(parity))
      EVEN:    par_bit_new = ^(head & data_mask);
      ODD:     par_bit_new = ~^(head & data_mask);
      MARK:    par_bit_new = 1'b1;
      default: par_bit_new = 1'b0;
    endcase
  end

  assign bit_done  = (cnt == bit_tc - ONE);
  assign stop_done = (cnt == stop_tc - ONE);
  assign pop       = !empty && cts_ok && ((state == IDLE) || ((state == STOP) && stop_done));
  assign level_nxt = fifo_level + LW'(push) - LW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_tc   <= (DIV_W+1)'(MIN_BAUD_DIV);
      stop_tc  <= (DIV_W+1)'(MIN_BAUD_DIV);
      shreg    <= '0;
      bit_idx  <= '0;
      last_bit <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      cnt <= cnt + ONE;
      if (pop) begin
        // Entered from IDLE or straight from the last stop clock: no idle gap.
        state    <= START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        cnt      <= '0;
        bit_tc   <= div_eff;
        stop_tc  <= stop_tc_new;
        shreg    <= head;
        bit_idx  <= '0;
        last_bit <= {1'b1, data_bits};
        par_en   <= (to_parity(parity) != NONE);
        par_bit  <= par_bit_new;
      end else begin
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            cnt  <= '0;
            busy <= (level_nxt != '0);
          end
          START: begin
            if (bit_done) begin
              state <= DATA;
              tx    <= shreg[0];
              cnt   <= '0;
            end
          end
          DATA: begin
            if (bit_done) begin
              cnt <= '0;
              if (bit_idx == last_bit) begin
                state <= par_en ? PARITY : STOP;
                tx    <= par_en ? par_bit : 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
              end
            end
          end
          PARITY: begin
            if (bit_done) begin
              state <= STOP;
              tx    <= 1'b1;
              cnt   <= '0;
            end
          end
          STOP: begin
            if (stop_done) begin
              state <= IDLE;
              tx    <= 1'b1;
              cnt   <= '0;
              busy  <= (level_nxt != '0);
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: directed frames with hand-computed waveforms.
// Builds with or without UART_TX_CTS_EN.
module tb_uart_tx_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [2:0]  parity;
  logic [1:0]  stop_bits;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_level;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  uart_tx_buffered_if s_if ();

  uart_tx_buffered #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s_if),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity     (parity),
    .stop_bits  (stop_bits),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef UART_TX_CTS_EN
    ,
    .cts_n      (cts_n)
`endif
  );

  always #5 clk = ~clk;

  // One expected frame: start/data/parity bits in order from bit 0, then stop clocks.
  typedef struct {
    int          div;
    int          nbits;
    logic [11:0] bits;
    int          stop;
    bit          contig;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int div, input int nbits, input logic [11:0] bits,
                              input int stop, input bit contig, input bit last);
    exp_t e;
    e.div = div; e.nbits = nbits; e.bits = bits;
    e.stop = stop; e.contig = contig; e.last = last;
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push_byte(input logic [7:0] d);
    int t;
    t = 0;
    s_if.s_data  = d;
    s_if.s_valid = 1'b1;
    while (!s_if.s_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("push_timeout", 32'(t), 0);
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input exp_t e);
    sb.push_back(e);
    push_byte(d);
  endtask

  task automatic monitor(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      exp_t e;
      int   gap;
      logic act;
      gap = 0;
      @(negedge clk);
      while (tx !== 1'b0 && gap < 2000) begin
        gap++;
        @(negedge clk);
      end
      if (gap >= 2000) begin
        check("frame_start_timeout", 32'(gap), 0);
        return;
      end
      if (sb.size() == 0) begin
        check("unexpected_frame", 1, 0);
        return;
      end
      e = sb.pop_front();
      if (e.contig) check($sformatf("gap_before_frame%0d", f), 32'(gap), 0);
      for (int b = 0; b < e.nbits; b++) begin
        act = e.bits[b];
        for (int c = 0; c < e.div; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (tx !== e.bits[b]) act = tx;
        end
        check($sformatf("frame%0d_bit%0d", f, b), 32'(act), 32'(e.bits[b]));
      end
      act = 1'b1;
      for (int c = 0; c < e.stop; c++) begin
        @(negedge clk);
        if (tx !== 1'b1) act = tx;
      end
      check($sformatf("frame%0d_stop", f), 32'(act), 1);
      if (e.last) begin
        check($sformatf("frame%0d_busy_last_stop", f), 32'(busy), 1);
        @(negedge clk);
        check($sformatf("frame%0d_busy_after", f), 32'(busy), 0);
        check($sformatf("frame%0d_tx_idle", f), 32'(tx), 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    baud_div     = 16'd4;
    data_bits    = 2'd3;
    parity       = 3'd0;
    stop_bits    = 2'd0;
    s_if.s_data  = 8'h00;
    s_if.s_valid = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n        = 1'b0;
`endif
    @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ready", 32'(s_if.s_ready), 1);
    @(negedge clk);
    rst = 1'b0;
`ifdef UART_TX_CTS_EN
    repeat (3) @(negedge clk);
`endif

    // 8N1 0x55 at div 4: 40-clock frame, tx falls one clock after the push.
    fork
      begin
        send(8'h55, mk(4, 9, 12'h0AA, 4, 0, 1));
        check("lat_tx_before_pop", 32'(tx), 1);
        check("lat_level_before_pop", 32'(fifo_level), 1);
        check("lat_busy_after_push", 32'(busy), 1);
        @(negedge clk);
        check("lat_tx_at_pop", 32'(tx), 0);
        check("lat_level_at_pop", 32'(fifo_level), 0);
      end
      monitor(1);
    join

    // 7E1.5 at div 5, 0x83 (bit 7 dropped): data 1100000, parity 0, stop 7 clocks.
    baud_div = 16'd5; data_bits = 2'd2; parity = 3'd1; stop_bits = 2'd2;
    fork
      send(8'h83, mk(5, 9, 12'h006, 7, 0, 1));
      monitor(1);
    join

    // Ten words back-to-back into an 8-deep FIFO: 9 accepted before s_ready drops.
    baud_div = 16'd4; data_bits = 2'd3; parity = 3'd0; stop_bits = 2'd0;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          logic [7:0] d;
          d = 8'(8'h11 * (i + 1));
          send(d, mk(4, 9, {3'b000, d, 1'b0}, 4, i != 0, 0));
        end
        check("burst_ready_full", 32'(s_if.s_ready), 0);
        check("burst_level_full", 32'(fifo_level), 8);
        send(8'hA5, mk(4, 9, {3'b000, 8'hA5, 1'b0}, 4, 1, 1));
      end
      monitor(10);
    join

    // Divisor below the minimum behaves as 4.
    baud_div = 16'd2;
    fork
      send(8'hA3, mk(4, 9, {3'b000, 8'hA3, 1'b0}, 4, 0, 1));
      monitor(1);
    join

    // Divisor changed mid-frame: current frame keeps 4, the queued one uses 8.
    baud_div = 16'd4;
    fork
      begin
        send(8'h0F, mk(4, 9, {3'b000, 8'h0F, 1'b0}, 4, 0, 0));
        send(8'hF0, mk(8, 9, {3'b000, 8'hF0, 1'b0}, 8, 1, 1));
        repeat (10) @(negedge clk);
        baud_div = 16'd8;
      end
      monitor(2);
    join

    // Reset during data bit 3 of a frame with three more words queued.
    baud_div = 16'd4;
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (15) @(negedge clk);
    check("pre_rst_tx_data0", 32'(tx), 0);
    check("pre_rst_level", 32'(fifo_level), 3);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(s_if.s_ready), 1);
    @(negedge clk);
    rst = 1'b0;
`ifdef UART_TX_CTS_EN
    repeat (3) @(negedge clk);
`endif
    fork
      send(8'h3C, mk(4, 9, {3'b000, 8'h3C, 1'b0}, 4, 0, 1));
      monitor(1);
    join

`ifdef UART_TX_CTS_EN
    // Held off by cts_n, released 3 clocks after cts_n falls, finishes despite cts_n rising.
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    fork
      begin
        send(8'h41, mk(4, 9, {3'b000, 8'h41, 1'b0}, 4, 0, 1));
        repeat (10) @(negedge clk);
        check("cts_hold_tx", 32'(tx), 1);
        check("cts_hold_level", 32'(fifo_level), 1);
        cts_n = 1'b0;
        @(negedge clk);
        check("cts_sync1_tx", 32'(tx), 1);
        @(negedge clk);
        check("cts_sync2_tx", 32'(tx), 1);
        @(negedge clk);
        check("cts_release_tx", 32'(tx), 0);
        repeat (12) @(negedge clk);
        cts_n = 1'b1;
      end
      monitor(1);
    join
`endif

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
